// File: rtl/noc_to_rv_bridge.sv
// Off-chip bridge: three credit-based NoC lanes to host ready/valid streams.
// Each lane buffers chip flits for the host and meters host flits by credits.
module noc_bridge_lane #(
    parameter int W          = 64,
    parameter int RX_DEPTH   = 4,
    parameter int TX_CREDITS = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         c2b_valid,
    input  logic [W-1:0] c2b_data,
    output logic         c2b_yummy,
    output logic         b2c_valid,
    output logic [W-1:0] b2c_data,
    input  logic         b2c_yummy,
    output logic         rx_valid,
    output logic [W-1:0] rx_data,
    input  logic         rx_ready,
    input  logic         tx_valid,
    input  logic [W-1:0] tx_data,
    output logic         tx_ready
);
    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int NW = $clog2(RX_DEPTH + 1);
    localparam int CW = $clog2(TX_CREDITS + 1);
    localparam logic [NW-1:0] FULL = NW'(RX_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(RX_DEPTH - 1);
    localparam logic [CW-1:0] CMAX = CW'(TX_CREDITS);

    logic [W-1:0]  mem_q [RX_DEPTH];
    logic [W-1:0]  mem_d [RX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          yummy_q, yummy_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          b2c_valid_q, b2c_valid_d;
    logic [W-1:0]  b2c_data_q, b2c_data_d;
    logic          wr_en, rd_en, send;

    // A write to a full FIFO is dropped even if the head leaves this cycle.
    always_comb begin
        rd_en    = (count_q != '0) && rx_ready;
        wr_en    = c2b_valid && (count_q != FULL);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = c2b_data;
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        yummy_d = rd_en;
    end

    always_comb begin
        send     = tx_valid && tx_ready;
        credit_d = credit_q;
        unique case ({send, b2c_yummy})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q != CMAX) credit_d = credit_q + CW'(1);
            end
            default: credit_d = credit_q;
        endcase
        b2c_valid_d = send;
        b2c_data_d  = send ? tx_data : b2c_data_q;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            yummy_q     <= 1'b0;
            credit_q    <= CMAX;
            b2c_valid_q <= 1'b0;
            b2c_data_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            yummy_q     <= yummy_d;
            credit_q    <= credit_d;
            b2c_valid_q <= b2c_valid_d;
            b2c_data_q  <= b2c_data_d;
        end
    end

    assign rx_valid  = (count_q != '0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign c2b_yummy = yummy_q;
    assign tx_ready  = (credit_q != '0);
    assign b2c_valid = b2c_valid_q;
    assign b2c_data  = b2c_data_q;
endmodule

module noc_to_rv_bridge #(
    parameter int NOC_DATA_WIDTH = 64,
    parameter int RX_DEPTH       = 4,
    parameter int TX_CREDITS     = 4
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      c2b_noc1_valid,
    input  logic [NOC_DATA_WIDTH-1:0] c2b_noc1_data,
    output logic                      c2b_noc1_yummy,
    output logic                      b2c_noc1_valid,
    output logic [NOC_DATA_WIDTH-1:0] b2c_noc1_data,
    input  logic                      b2c_noc1_yummy,
    output logic                      rx_noc1_valid,
    output logic [NOC_DATA_WIDTH-1:0] rx_noc1_data,
    input  logic                      rx_noc1_ready,
    input  logic                      tx_noc1_valid,
    input  logic [NOC_DATA_WIDTH-1:0] tx_noc1_data,
    output logic                      tx_noc1_ready,
    input  logic                      c2b_noc2_valid,
    input  logic [NOC_DATA_WIDTH-1:0] c2b_noc2_data,
    output logic                      c2b_noc2_yummy,
    output logic                      b2c_noc2_valid,
    output logic [NOC_DATA_WIDTH-1:0] b2c_noc2_data,
    input  logic                      b2c_noc2_yummy,
    output logic                      rx_noc2_valid,
    output logic [NOC_DATA_WIDTH-1:0] rx_noc2_data,
    input  logic                      rx_noc2_ready,
    input  logic                      tx_noc2_valid,
    input  logic [NOC_DATA_WIDTH-1:0] tx_noc2_data,
    output logic                      tx_noc2_ready,
    input  logic                      c2b_noc3_valid,
    input  logic [NOC_DATA_WIDTH-1:0] c2b_noc3_data,
    output logic                      c2b_noc3_yummy,
    output logic                      b2c_noc3_valid,
    output logic [NOC_DATA_WIDTH-1:0] b2c_noc3_data,
    input  logic                      b2c_noc3_yummy,
    output logic                      rx_noc3_valid,
    output logic [NOC_DATA_WIDTH-1:0] rx_noc3_data,
    input  logic                      rx_noc3_ready,
    input  logic                      tx_noc3_valid,
    input  logic [NOC_DATA_WIDTH-1:0] tx_noc3_data,
    output logic                      tx_noc3_ready
);
    noc_bridge_lane #(.W(NOC_DATA_WIDTH), .RX_DEPTH(RX_DEPTH), .TX_CREDITS(TX_CREDITS)) u_noc1 (
        .clock(clock), .rst_n(rst_n),
        .c2b_valid(c2b_noc1_valid), .c2b_data(c2b_noc1_data), .c2b_yummy(c2b_noc1_yummy),
        .b2c_valid(b2c_noc1_valid), .b2c_data(b2c_noc1_data), .b2c_yummy(b2c_noc1_yummy),
        .rx_valid(rx_noc1_valid), .rx_data(rx_noc1_data), .rx_ready(rx_noc1_ready),
        .tx_valid(tx_noc1_valid), .tx_data(tx_noc1_data), .tx_ready(tx_noc1_ready)
    );

    noc_bridge_lane #(.W(NOC_DATA_WIDTH), .RX_DEPTH(RX_DEPTH), .TX_CREDITS(TX_CREDITS)) u_noc2 (
        .clock(clock), .rst_n(rst_n),
        .c2b_valid(c2b_noc2_valid), .c2b_data(c2b_noc2_data), .c2b_yummy(c2b_noc2_yummy),
        .b2c_valid(b2c_noc2_valid), .b2c_data(b2c_noc2_data), .b2c_yummy(b2c_noc2_yummy),
        .rx_valid(rx_noc2_valid), .rx_data(rx_noc2_data), .rx_ready(rx_noc2_ready),
        .tx_valid(tx_noc2_valid), .tx_data(tx_noc2_data), .tx_ready(tx_noc2_ready)
    );

    noc_bridge_lane #(.W(NOC_DATA_WIDTH), .RX_DEPTH(RX_DEPTH), .TX_CREDITS(TX_CREDITS)) u_noc3 (
        .clock(clock), .rst_n(rst_n),
        .c2b_valid(c2b_noc3_valid), .c2b_data(c2b_noc3_data), .c2b_yummy(c2b_noc3_yummy),
        .b2c_valid(b2c_noc3_valid), .b2c_data(b2c_noc3_data), .b2c_yummy(b2c_noc3_yummy),
        .rx_valid(rx_noc3_valid), .rx_data(rx_noc3_data), .rx_ready(rx_noc3_ready),
        .tx_valid(tx_noc3_valid), .tx_data(tx_noc3_data), .tx_ready(tx_noc3_ready)
    );
endmodule

// File: tb/tb_noc_to_rv_bridge.sv
// Bench for noc_to_rv_bridge: vector table, directed corner sequences,
// and random traffic against a queue/credit-count reference model.
module tb_noc_to_rv_bridge;
    localparam int D = 4;
    localparam int C = 4;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]       c2b_valid, c2b_yummy, b2c_valid, b2c_yummy;
    logic [2:0]       rx_valid, rx_ready, tx_valid, tx_ready;
    logic [2:0][63:0] c2b_data, b2c_data, rx_data, tx_data;

    noc_to_rv_bridge #(.NOC_DATA_WIDTH(64), .RX_DEPTH(D), .TX_CREDITS(C)) dut (
        .clock(clock), .rst_n(rst_n),
        .c2b_noc1_valid(c2b_valid[0]), .c2b_noc1_data(c2b_data[0]), .c2b_noc1_yummy(c2b_yummy[0]),
        .b2c_noc1_valid(b2c_valid[0]), .b2c_noc1_data(b2c_data[0]), .b2c_noc1_yummy(b2c_yummy[0]),
        .rx_noc1_valid(rx_valid[0]), .rx_noc1_data(rx_data[0]), .rx_noc1_ready(rx_ready[0]),
        .tx_noc1_valid(tx_valid[0]), .tx_noc1_data(tx_data[0]), .tx_noc1_ready(tx_ready[0]),
        .c2b_noc2_valid(c2b_valid[1]), .c2b_noc2_data(c2b_data[1]), .c2b_noc2_yummy(c2b_yummy[1]),
        .b2c_noc2_valid(b2c_valid[1]), .b2c_noc2_data(b2c_data[1]), .b2c_noc2_yummy(b2c_yummy[1]),
        .rx_noc2_valid(rx_valid[1]), .rx_noc2_data(rx_data[1]), .rx_noc2_ready(rx_ready[1]),
        .tx_noc2_valid(tx_valid[1]), .tx_noc2_data(tx_data[1]), .tx_noc2_ready(tx_ready[1]),
        .c2b_noc3_valid(c2b_valid[2]), .c2b_noc3_data(c2b_data[2]), .c2b_noc3_yummy(c2b_yummy[2]),
        .b2c_noc3_valid(b2c_valid[2]), .b2c_noc3_data(b2c_data[2]), .b2c_noc3_yummy(b2c_yummy[2]),
        .rx_noc3_valid(rx_valid[2]), .rx_noc3_data(rx_data[2]), .rx_noc3_ready(rx_ready[2]),
        .tx_noc3_valid(tx_valid[2]), .tx_noc3_data(tx_data[2]), .tx_noc3_ready(tx_ready[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue per lane and an integer credit count.
    logic [63:0] mq [3][$];
    int          mcred [3];
    logic        m_yummy [3];
    logic        m_bval [3];
    logic [63:0] m_bdata [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mcred[i]   = C;
            m_yummy[i] = 1'b0;
            m_bval[i]  = 1'b0;
            m_bdata[i] = '0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit deq, wr, snd;
            deq = (mq[i].size() != 0) && rx_ready[i];
            wr  = c2b_valid[i] && (mq[i].size() < D);
            m_yummy[i] = deq;
            if (deq) void'(mq[i].pop_front());
            if (wr) mq[i].push_back(c2b_data[i]);
            snd = tx_valid[i] && (mcred[i] > 0);
            mcred[i] = mcred[i] - int'(snd) + int'(b2c_yummy[i]);
            if (mcred[i] > C) mcred[i] = C;
            m_bval[i] = snd;
            if (snd) m_bdata[i] = tx_data[i];
        end
    endtask

    task automatic cmp_model(int i, int cyc);
        string p;
        p = $sformatf("rnd%0d noc%0d", cyc, i + 1);
        chk({p, " rx_valid"}, 64'(rx_valid[i]), 64'(mq[i].size() != 0));
        if (mq[i].size() != 0) chk({p, " rx_data"}, rx_data[i], mq[i][0]);
        chk({p, " c2b_yummy"}, 64'(c2b_yummy[i]), 64'(m_yummy[i]));
        chk({p, " tx_ready"}, 64'(tx_ready[i]), 64'(mcred[i] != 0));
        chk({p, " b2c_valid"}, 64'(b2c_valid[i]), 64'(m_bval[i]));
        chk({p, " b2c_data"}, b2c_data[i], m_bdata[i]);
    endtask

    task automatic clear_inputs();
        c2b_valid = '0; c2b_data = '0; b2c_yummy = '0;
        rx_ready  = '0; tx_valid = '0; tx_data  = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst_n = 1'b0;
        #13;
        @(negedge clock);
        rst_n = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        cv;
        logic [63:0] cd;
        logic        rr;
        logic        tv;
        logic [63:0] td;
        logic        by;
        logic        e_rv;
        logic [63:0] e_rd;
        logic        e_y;
        logic        e_tr;
        logic        e_bv;
        logic [63:0] e_bd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic cv, logic [63:0] cd, logic rr, logic tv,
                                logic [63:0] td, logic by, logic e_rv, logic [63:0] e_rd,
                                logic e_y, logic e_tr, logic e_bv, logic [63:0] e_bd);
        vec_t v;
        v.cv = cv; v.cd = cd; v.rr = rr; v.tv = tv; v.td = td; v.by = by;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_y = e_y;
        v.e_tr = e_tr; v.e_bv = e_bv; v.e_bd = e_bd;
        return v;
    endfunction

    initial begin
        logic [63:0] got[$];
        int n_y;
        vec_t v;

        // receive flow, hold, simultaneous write+dequeue
        tbl.push_back(mk(1, 64'h11, 0, 0, 0, 0, 1, 64'h11, 0, 1, 0, 0));
        tbl.push_back(mk(1, 64'h22, 0, 0, 0, 0, 1, 64'h11, 0, 1, 0, 0));
        tbl.push_back(mk(1, 64'h33, 0, 0, 0, 0, 1, 64'h11, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h11, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 64'h22, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 64'h33, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 64'h44, 0, 0, 0, 0, 1, 64'h44, 0, 1, 0, 0));
        tbl.push_back(mk(1, 64'h55, 1, 0, 0, 0, 1, 64'h55, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // credits: exhaust, blocked send, replenish, send+yummy, saturation
        tbl.push_back(mk(0, 0, 0, 1, 64'hA1, 0, 0, 0, 0, 1, 1, 64'hA1));
        tbl.push_back(mk(0, 0, 0, 1, 64'hA2, 0, 0, 0, 0, 1, 1, 64'hA2));
        tbl.push_back(mk(0, 0, 0, 1, 64'hA3, 0, 0, 0, 0, 1, 1, 64'hA3));
        tbl.push_back(mk(0, 0, 0, 1, 64'hA4, 0, 0, 0, 0, 0, 1, 64'hA4));
        tbl.push_back(mk(0, 0, 0, 1, 64'hA5, 0, 0, 0, 0, 0, 0, 64'hA4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 64'hA4));
        tbl.push_back(mk(0, 0, 0, 1, 64'hB1, 1, 0, 0, 0, 1, 1, 64'hB1));
        tbl.push_back(mk(0, 0, 0, 1, 64'hB2, 0, 0, 0, 0, 0, 1, 64'hB2));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 64'hB2));
        tbl.push_back(mk(0, 0, 0, 1, 64'hC1, 0, 0, 0, 0, 1, 1, 64'hC1));
        tbl.push_back(mk(0, 0, 0, 1, 64'hC2, 0, 0, 0, 0, 1, 1, 64'hC2));
        tbl.push_back(mk(0, 0, 0, 1, 64'hC3, 0, 0, 0, 0, 1, 1, 64'hC3));
        tbl.push_back(mk(0, 0, 0, 1, 64'hC4, 0, 0, 0, 0, 0, 1, 64'hC4));
        tbl.push_back(mk(0, 0, 0, 1, 64'hC5, 0, 0, 0, 0, 0, 0, 64'hC4));

        clear_inputs();
        model_reset();
        do_reset();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst noc%0d rx_valid", i + 1), 64'(rx_valid[i]), 0);
            chk($sformatf("rst noc%0d c2b_yummy", i + 1), 64'(c2b_yummy[i]), 0);
            chk($sformatf("rst noc%0d b2c_valid", i + 1), 64'(b2c_valid[i]), 0);
            chk($sformatf("rst noc%0d b2c_data", i + 1), b2c_data[i], 0);
            chk($sformatf("rst noc%0d tx_ready", i + 1), 64'(tx_ready[i]), 1);
        end

        for (int k = 0; k < 4; k++) begin
            tx_valid[1] = 1'b1;
            tx_data[1]  = 64'h200 + 64'(k);
            tick();
            chk($sformatf("noc2 send%0d b2c_valid", k), 64'(b2c_valid[1]), 1);
            chk($sformatf("noc2 send%0d b2c_data", k), b2c_data[1], 64'h200 + 64'(k));
            chk($sformatf("noc2 send%0d tx_ready", k), 64'(tx_ready[1]), (k < 3) ? 1 : 0);
        end
        tick();
        chk("noc2 blocked b2c_valid", 64'(b2c_valid[1]), 0);
        chk("noc2 blocked tx_ready", 64'(tx_ready[1]), 0);
        tx_valid[1] = 1'b0;

        for (int k = 0; k < 4; k++) begin
            tx_valid[2] = 1'b1;
            tx_data[2]  = 64'h300 + 64'(k);
            tick();
        end
        tx_valid[2] = 1'b0;
        chk("noc3 empty tx_ready", 64'(tx_ready[2]), 0);
        b2c_yummy[2] = 1'b1;
        tick();
        b2c_yummy[2] = 1'b0;
        chk("noc3 replenish tx_ready", 64'(tx_ready[2]), 1);
        tx_valid[2] = 1'b1;
        tx_data[2]  = 64'h3AA;
        tick();
        chk("noc3 one send b2c_valid", 64'(b2c_valid[2]), 1);
        chk("noc3 one send tx_ready", 64'(tx_ready[2]), 0);
        tick();
        chk("noc3 second blocked b2c_valid", 64'(b2c_valid[2]), 0);
        tx_valid[2] = 1'b0;

        do_reset();
        foreach (tbl[r]) begin
            v = tbl[r];
            c2b_valid[0] = v.cv; c2b_data[0] = v.cd; rx_ready[0] = v.rr;
            tx_valid[0]  = v.tv; tx_data[0]  = v.td; b2c_yummy[0] = v.by;
            tick();
            chk($sformatf("vec%0d rx_valid", r), 64'(rx_valid[0]), 64'(v.e_rv));
            if (v.e_rv) chk($sformatf("vec%0d rx_data", r), rx_data[0], v.e_rd);
            chk($sformatf("vec%0d c2b_yummy", r), 64'(c2b_yummy[0]), 64'(v.e_y));
            chk($sformatf("vec%0d tx_ready", r), 64'(tx_ready[0]), 64'(v.e_tr));
            chk($sformatf("vec%0d b2c_valid", r), 64'(b2c_valid[0]), 64'(v.e_bv));
            chk($sformatf("vec%0d b2c_data", r), b2c_data[0], v.e_bd);
            for (int j = 1; j < 3; j++)
                chk($sformatf("vec%0d iso noc%0d", r, j + 1),
                    {60'd0, rx_valid[j], c2b_yummy[j], b2c_valid[j], tx_ready[j]}, 64'b0001);
        end

        do_reset();
        for (int k = 0; k < 4; k++) begin
            c2b_valid[0] = 1'b1;
            c2b_data[0]  = 64'hF0 + 64'(k);
            tick();
        end
        chk("full rx_valid", 64'(rx_valid[0]), 1);
        chk("full head", rx_data[0], 64'hF0);
        c2b_data[0] = 64'hF4;
        tick();
        chk("overflow head held", rx_data[0], 64'hF0);
        chk("overflow no yummy", 64'(c2b_yummy[0]), 0);
        n_y = 0;
        c2b_data[0] = 64'hF5;
        rx_ready[0] = 1'b1;
        if (rx_valid[0]) got.push_back(rx_data[0]);
        tick();
        n_y += int'(c2b_yummy[0]);
        chk("full write+deq head", rx_data[0], 64'hF1);
        c2b_valid[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rx_valid[0]) got.push_back(rx_data[0]);
            tick();
            n_y += int'(c2b_yummy[0]);
        end
        rx_ready[0] = 1'b0;
        chk("drain count", 64'(got.size()), 4);
        for (int k = 0; k < got.size() && k < 4; k++)
            chk($sformatf("drain order %0d", k), got[k], 64'hF0 + 64'(k));
        chk("drain yummies", 64'(n_y), 4);
        chk("drain rx_valid", 64'(rx_valid[0]), 0);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            c2b_valid[0] = (k < 2);
            c2b_data[0]  = 64'hD0 + 64'(k);
            tx_valid[2]  = 1'b1;
            tx_data[2]   = 64'hE0 + 64'(k);
            tick();
        end
        chk("pre-rst noc1 rx_valid", 64'(rx_valid[0]), 1);
        chk("pre-rst noc3 tx_ready", 64'(tx_ready[2]), 0);
        chk("pre-rst noc2 rx_valid", 64'(rx_valid[1]), 0);
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst noc1 rx_valid", 64'(rx_valid[0]), 0);
        chk("mid-rst noc3 tx_ready", 64'(tx_ready[2]), 1);
        chk("mid-rst noc3 b2c_valid", 64'(b2c_valid[2]), 0);
        chk("mid-rst noc3 b2c_data", b2c_data[2], 0);
        @(negedge clock);
        rst_n = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        chk("post-rst noc1 rx_valid", 64'(rx_valid[0]), 0);
        for (int k = 0; k < 4; k++) begin
            tx_valid[2] = 1'b1;
            tx_data[2]  = 64'h900 + 64'(k);
            tick();
            chk($sformatf("post-rst send%0d tx_ready", k), 64'(tx_ready[2]), (k < 3) ? 1 : 0);
        end

        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                c2b_valid[i] = ($urandom_range(0, 99) < 45);
                c2b_data[i]  = {$urandom, $urandom};
                rx_ready[i]  = ($urandom_range(0, 99) < 55);
                tx_valid[i]  = ($urandom_range(0, 99) < 60);
                tx_data[i]   = {$urandom, $urandom};
                b2c_yummy[i] = ($urandom_range(0, 99) < 40);
            end
            tick();
            for (int i = 0; i < 3; i++) cmp_model(i, cyc);
        end

        clear_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/noc_to_rv_bridge.md
# noc_to_rv_bridge

Off-chip bridge between the processor's three credit-based NoC channels (valid/data/yummy) and three host-side ready/valid streams per direction. It sits outside `chip`, on the `processor_offchip_*` / `offchip_processor_*` pins. It buffers chip-to-host flits and returns one yummy (credit) per flit consumed. It meters host-to-chip flits against a per-network credit counter replenished by the chip's yummies. The three networks (1, 2, 3) are independent, identical lanes.

## Interface
Parameters:
- NOC_DATA_WIDTH, 64: flit width (matches `NOC_DATA_WIDTH`).
- RX_DEPTH, 4: per-network receive FIFO depth; equals the credits the chip's sender holds for this bridge.
- TX_CREDITS, 4: initial and maximum credits toward the chip's per-network input buffer.

Ports (N = 1, 2, 3; one set per network):
- clock  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- c2b_nocN_valid  in  1  chip flit valid.
- c2b_nocN_data  in  NOC_DATA_WIDTH  chip flit.
- c2b_nocN_yummy  out  1  one-cycle credit return to chip.
- b2c_nocN_valid  out  1  flit valid to chip.
- b2c_nocN_data  out  NOC_DATA_WIDTH  flit to chip.
- b2c_nocN_yummy  in  1  credit return from chip.
- rx_nocN_valid  out  1  host-side receive stream valid (FIFO non-empty).
- rx_nocN_data  out  NOC_DATA_WIDTH  FIFO head flit.
- rx_nocN_ready  in  1  host accepts head flit.
- tx_nocN_valid  in  1  host transmit flit valid.
- tx_nocN_data  in  NOC_DATA_WIDTH  host transmit flit.
- tx_nocN_ready  out  1  bridge holds at least one credit.

## Operation
- Receive lane (chip to host): each cycle with c2b_nocN_valid=1, the flit is written to the FIFO tail. The FIFO holds RX_DEPTH entries.
- rx_nocN_valid = FIFO non-empty. rx_nocN_data = head, stable while valid and not ready.
- A dequeue occurs when rx valid and ready are both 1. Each dequeue produces exactly one c2b_nocN_yummy pulse.
- Write to a full FIFO is a protocol violation. The flit is discarded and FIFO state is unchanged. The same-cycle dequeue still proceeds, and the write is not accepted that cycle.
- Simultaneous write and dequeue on a non-empty FIFO: both occur and the count is unchanged. On an empty FIFO, the written flit is not visible until the next cycle; there is no bypass.
- Transmit lane (host to chip): the credit counter resets to TX_CREDITS. tx_nocN_ready = (credits != 0), combinational from the counter only.
- A send occurs when tx valid and ready are both 1. The flit is registered onto b2c_nocN_data, and b2c_nocN_valid pulses for one cycle. The send costs one credit.
- b2c_nocN_yummy=1 adds one credit.
- Send and yummy in the same cycle leave the count unchanged.
- The count saturates at TX_CREDITS; excess yummies are ignored. It never goes below 0.
- Networks never interact. Flit order is preserved per lane.

## Timing
- Reset (rst_n=0, asynchronous) sets:
  - all c2b_nocN_yummy, b2c_nocN_valid, rx_nocN_valid to 0;
  - b2c_nocN_data to 0;
  - FIFOs empty;
  - credits to TX_CREDITS, so tx_nocN_ready=1 immediately after reset deasserts.
- Reset mid-operation drops all buffered and in-flight flits; the chip is reset together with the bridge.
- c2b flit sampled at edge t gives rx_nocN_valid=1 in cycle t+1 (1-cycle latency).
- Dequeue at edge t gives c2b_nocN_yummy=1 for cycle t+1 only. Back-to-back dequeues give back-to-back yummies.
- tx handshake at edge t gives b2c_nocN_valid=1 and b2c_nocN_data=flit during cycle t+1. Full throughput: one flit per cycle while credits last.
- A yummy sampled at edge t makes credits visible in cycle t+1, so tx_nocN_ready rises in cycle t+1 from 0 credits.
- b2c_nocN_data holds its last value when valid=0.

## Test plan
- Reset check: after reset, all outputs are 0 and tx_noc1..3_ready=1. Four sends on noc2 with no yummies give four b2c_noc2_valid pulses, then tx_noc2_ready=0.
- Receive flow: drive c2b_noc1 flits 0x11, 0x22, 0x33 on consecutive cycles with rx_noc1_ready=0. rx_noc1_data=0x11 is held. Raise ready: 0x11, 0x22, 0x33 dequeue in order, with three single-cycle c2b_noc1_yummy pulses, each one cycle after its dequeue.
- Credit replenish: exhaust noc3 credits, pulse b2c_noc3_yummy once. tx_noc3_ready=1 next cycle for exactly one send, then returns to 0.
- Simultaneous: send and yummy in the same cycle with credits=1. Credits stay 1 and ready stays 1. Four extra yummies at credits=4 keep it at 4, so a fifth consecutive send is blocked.
- FIFO boundary: fill noc1 with 4 flits, drive a 5th with ready=0. The 5th is discarded, 4 dequeues follow, and exactly 4 yummies are returned.
- Isolation and reset mid-stream: traffic on noc1 does not affect noc2/noc3 outputs. Asserting rst_n=0 with 2 flits buffered clears rx_valid immediately and restores credits to 4.
